// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and debounces QuadA/QuadB, then turns
// accepted phase changes into a wrapping up/down Count with Step/Dir/Err.
module quad_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             QuadA,
  input  logic             QuadB,
  input  logic             Clear,
  output logic [WIDTH-1:0] Count,
  output logic             Dir,
  output logic             Step,
  output logic             Err
);

  localparam int SN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int FL = (FILTER_LEN < 1) ? 1 : FILTER_LEN;
  localparam int CW = $clog2(FL + 1);
  localparam logic [CW-1:0] FL_CNT = CW'(FL);

  logic [SN-1:0]    sync_a_q, sync_a_d;
  logic [SN-1:0]    sync_b_q, sync_b_d;
  logic [1:0]       ab_sync;

  logic [1:0]       filt_q, filt_d;
  logic [1:0]       cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             armed_q, armed_d;
  logic [1:0]       delta;

  // Position of a phase on the 00->10->11->01 cycle; up steps advance it by one.
  function automatic logic [1:0] phase_of(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  always_comb begin
    sync_a_d = {sync_a_q[SN-2:0], QuadA};
    sync_b_d = {sync_b_q[SN-2:0], QuadB};
  end

  assign ab_sync = {sync_a_q[SN-1], sync_b_q[SN-1]};

  // A candidate must be seen FL consecutive cycles; the following cycle commits it.
  always_comb begin
    filt_d = filt_q;
    cand_d = cand_q;
    cnt_d  = '0;
    accept = 1'b0;
    if (cnt_q == FL_CNT) begin
      accept = 1'b1;
      filt_d = cand_q;
    end else if (ab_sync != filt_q) begin
      cand_d = ab_sync;
      if ((cnt_q != '0) && (ab_sync == cand_q)) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = CW'(1);
      end
    end
  end

  assign delta = phase_of(cand_q) - phase_of(filt_q);

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = err_q;
    armed_d = armed_q;
    if (Clear) begin
      count_d = '0;
      err_d   = 1'b0;
      armed_d = 1'b0;
    end else if (accept) begin
      if (!armed_q) begin
        armed_d = 1'b1;
      end else begin
        case (delta)
          2'd1: begin
            count_d = count_q + WIDTH'(1);
            dir_d   = 1'b1;
            step_d  = 1'b1;
          end
          2'd3: begin
            count_d = count_q - WIDTH'(1);
            dir_d   = 1'b0;
            step_d  = 1'b1;
          end
          2'd2: err_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      filt_q   <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
      dir_q    <= 1'b1;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sync_a_q <= sync_a_d;
      sync_b_q <= sync_b_d;
      filt_q   <= filt_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
      armed_q  <= armed_d;
    end
  end

  assign Count = count_q;
  assign Dir   = dir_q;
  assign Step  = step_q;
  assign Err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Randomised scoreboard bench for quad_decoder: stimulus schedules expected
// accept events by the fixed latency, a monitor pops and compares them.
module tb_quad_decoder;
  localparam int WIDTH = 4;
  localparam int S     = 2;
  localparam int F     = 3;
  localparam int M     = 1 << WIDTH;
  localparam int MAXC  = 16384;

  logic             Clk = 1'b0;
  logic             reset, QuadA, QuadB, Clear;
  logic [WIDTH-1:0] Count;
  logic             Dir, Step, Err;

  quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(S), .FILTER_LEN(F)) dut (
    .Clk(Clk), .reset(reset), .QuadA(QuadA), .QuadB(QuadB), .Clear(Clear),
    .Count(Count), .Dir(Dir), .Step(Step), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int   edge_no;
    logic is_step;
    int   count;
    logic dir;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bit         ev_v  [MAXC];
  logic [1:0] ev_l  [MAXC];
  bit         clr_at[MAXC];

  // Reference state: position on the quadrature cycle, not the RTL encoding.
  int         pos_tab[4] = '{0, 3, 1, 2};
  logic [1:0] lvl_tab[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int         m_count;
  bit         m_dir, m_err, m_armed;
  logic [1:0] m_filt;
  logic [1:0] acc_level, cur_level;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input int e);
    exp_t x;
    int   d;
    if (clr_at[e]) begin
      m_count = 0;
      m_err   = 0;
      m_armed = 0;
    end else if (ev_v[e]) begin
      if (!m_armed) begin
        m_armed = 1;
      end else begin
        d = (pos_tab[ev_l[e]] - pos_tab[m_filt] + 4) % 4;
        x.edge_no = e;
        if (d == 1 || d == 3) begin
          m_count   = (d == 1) ? (m_count + 1) % M : (m_count + M - 1) % M;
          m_dir     = (d == 1);
          x.is_step = 1'b1;
          x.count   = m_count;
          x.dir     = m_dir;
          sb.push_back(x);
        end else if (d == 2 && !m_err) begin
          m_err     = 1;
          x.is_step = 1'b0;
          x.count   = m_count;
          x.dir     = m_dir;
          sb.push_back(x);
        end
      end
    end
    if (ev_v[e]) m_filt = ev_l[e];
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      cyc++;
      if (!reset && cyc < MAXC) model_edge(cyc);
    end
  end

  initial begin
    bit   err_prev = 0;
    exp_t x;
    forever begin
      @(negedge Clk);
      if (!reset) begin
        check("count", int'(Count), m_count);
        check("dir", int'(Dir), int'(m_dir));
        check("err", int'(Err), int'(m_err));
        if (Step || (Err && !err_prev)) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event at cycle %0d: step=%0d err=%0d, expected no event",
                     cyc, Step, Err);
          end else begin
            x = sb.pop_front();
            check("event_edge", cyc, x.edge_no);
            check("event_step", int'(Step), int'(x.is_step));
            check("event_count", int'(Count), x.count);
            check("event_dir", int'(Dir), int'(x.dir));
          end
        end
        err_prev = Err;
      end
    end
  end

  task automatic tick(input int n, input int clr_pct);
    for (int i = 0; i < n; i++) begin
      Clear = ($urandom_range(99) < clr_pct);
      if (Clear) clr_at[cyc + 1] = 1'b1;
      @(posedge Clk);
      #1;
    end
    Clear = 1'b0;
  endtask

  task automatic set_level(input logic [1:0] l);
    {QuadA, QuadB} = l;
    cur_level = l;
    if (l != acc_level) begin
      ev_v[cyc + 1 + S + F] = 1'b1;
      ev_l[cyc + 1 + S + F] = l;
      acc_level = l;
    end
  endtask

  task automatic hold(input logic [1:0] l, input int n, input int clr_pct);
    set_level(l);
    tick(n, clr_pct);
  endtask

  task automatic glitch(input logic [1:0] g, input int len);
    {QuadA, QuadB} = g;
    tick(len, 0);
    {QuadA, QuadB} = cur_level;
    tick(2, 0);
  endtask

  function automatic logic [1:0] step_from(input logic [1:0] l, input int by);
    return lvl_tab[(pos_tab[l] + by) % 4];
  endfunction

  task automatic mid_reset();
    #1 reset = 1'b1;
    #1;
    check("async_reset_count", int'(Count), 0);
    check("async_reset_dir", int'(Dir), 1);
    check("async_reset_err", int'(Err), 0);
    check("async_reset_step", int'(Step), 0);
    #1 reset = 1'b0;
    m_count = 0; m_dir = 1; m_err = 0; m_armed = 0; m_filt = 2'b00;
    sb.delete();
    for (int i = cyc + 1; i < MAXC; i++) begin
      ev_v[i]   = 1'b0;
      clr_at[i] = 1'b0;
    end
    acc_level = 2'b00;
    @(posedge Clk);
    #1;
    set_level(cur_level);
    tick(F + 3, 0);
  endtask

  task automatic random_phase(input int n);
    int r;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(9);
      if (r < 6) begin
        hold(step_from(acc_level, ($urandom_range(1) != 0) ? 1 : 3),
             $urandom_range(F + 6, F + 1), 3);
      end else if (r < 8) begin
        glitch(step_from(cur_level, $urandom_range(3, 1)), $urandom_range(F - 1, 1));
      end else begin
        hold(step_from(acc_level, 2), $urandom_range(F + 6, F + 1), 3);
      end
    end
  endtask

  initial begin
    reset = 1'b1; QuadA = 1'b0; QuadB = 1'b0; Clear = 1'b0;
    acc_level = 2'b00; cur_level = 2'b00;
    m_count = 0; m_dir = 1; m_err = 0; m_armed = 0; m_filt = 2'b00;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_count", int'(Count), 0);
    check("reset_dir", int'(Dir), 1);
    check("reset_step", int'(Step), 0);
    check("reset_err", int'(Err), 0);
    reset = 1'b0;

    hold(2'b11, 10, 0);
    hold(2'b01, 8, 0);
    hold(2'b00, 8, 0);
    hold(2'b10, 8, 0); hold(2'b11, 8, 0); hold(2'b01, 8, 0); hold(2'b00, 8, 0);
    hold(2'b01, 8, 0); hold(2'b11, 8, 0); hold(2'b10, 8, 0); hold(2'b00, 8, 0);
    for (int i = 0; i < 4; i++) begin
      hold(2'b10, F + 1, 0); hold(2'b11, F + 1, 0);
      hold(2'b01, F + 1, 0); hold(2'b00, F + 1, 0);
    end
    tick(S + 2, 0);
    glitch(2'b10, F - 1);
    hold(2'b11, 8, 0);

    // Clear lands on the very edge the 11->01 step is decoded.
    set_level(2'b01);
    tick(S + F, 0);
    Clear = 1'b1;
    clr_at[cyc + 1] = 1'b1;
    @(posedge Clk);
    #1;
    Clear = 1'b0;
    tick(4, 0);
    hold(2'b00, 8, 0);
    hold(2'b10, 8, 0);

    random_phase(150);

    for (int i = 0; i < 40 && !(m_armed && m_count == 7); i++) begin
      hold(step_from(acc_level, 1), S + F + 2, 0);
    end
    mid_reset();

    random_phase(80);
    tick(S + F + 6, 0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
